// File: rtl/lgate_rr_arbiter.sv
// lgate_rr_arbiter: round-robin arbiter in front of one shared, registered
// bitwise logic unit. One operation is in flight at a time, and each result
// is returned with the id of the requester that issued it.
// Optional feature macro: LGATE_ARB_ILLEGAL_OP_EN
//   defined   : op 7 is illegal, so result = 0 and err pulses with done
//   undefined : op 7 passes operand a through, and err is tied low
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no operation in flight; arbitrate whenever any req is high
// EXEC  | winner's operands are latched; compute the result this cycle
// RESP  | result, result_id and done are valid for exactly one cycle
module lgate_rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NREQ-1:0]            req,
  input  logic [3*NREQ-1:0]          op_bus,
  input  logic [WIDTH*NREQ-1:0]      a_bus,
  input  logic [WIDTH*NREQ-1:0]      b_bus,
  output logic [NREQ-1:0]            gnt,
  output logic                       busy,
  output logic [NREQ-1:0]            done,
  output logic [WIDTH-1:0]           result,
  output logic [$clog2(NREQ)-1:0]    result_id,
  output logic                       err
);

  localparam int ID_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ID_W-1:0]   ptr_q;
  logic [ID_W-1:0]   win_q;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  a_q, b_q;

  logic              win_found;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   cand;
  logic [WIDTH-1:0]  calc;
`ifdef LGATE_ARB_ILLEGAL_OP_EN
  logic              calc_err;
  logic              err_q;
`endif

  // Winner is the first requester at or after ptr. NREQ is a power of two,
  // so ID_W-bit addition wraps modulo NREQ on its own.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < NREQ; i++) begin
      cand = ptr_q + ID_W'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Bitwise function of the latched operands.
  always_comb begin
    calc = '0;
`ifdef LGATE_ARB_ILLEGAL_OP_EN
    calc_err = 1'b0;
`endif
    unique case (op_q)
      3'd0: calc = a_q & b_q;
      3'd1: calc = a_q | b_q;
      3'd2: calc = a_q ^ b_q;
      3'd3: calc = ~(a_q & b_q);
      3'd4: calc = ~(a_q | b_q);
      3'd5: calc = ~(a_q ^ b_q);
      3'd6: calc = ~a_q;
      default: begin
`ifdef LGATE_ARB_ILLEGAL_OP_EN
        calc     = '0;
        calc_err = 1'b1;
`else
        calc     = a_q;
`endif
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: a fixed three-step cycle, leaving IDLE only when there is a winner.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (win_found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Latch the winner on grant, compute in EXEC, and retire the grant in RESP.
  // Operands are latched on grant so that requester bus activity cannot
  // disturb an operation that is already in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q     <= '0;
      win_q     <= '0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      gnt       <= '0;
      done      <= '0;
      result    <= '0;
      result_id <= '0;
`ifdef LGATE_ARB_ILLEGAL_OP_EN
      err_q     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_found) begin
            op_q  <= op_bus[3*int'(win_idx) +: 3];
            a_q   <= a_bus[WIDTH*int'(win_idx) +: WIDTH];
            b_q   <= b_bus[WIDTH*int'(win_idx) +: WIDTH];
            win_q <= win_idx;
            gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << win_idx;
            ptr_q <= win_idx + ID_W'(1);
          end
        end
        EXEC: begin
          result    <= calc;
          result_id <= win_q;
          done      <= gnt;
`ifdef LGATE_ARB_ILLEGAL_OP_EN
          err_q     <= calc_err;
`endif
        end
        RESP: begin
          done  <= '0;
          gnt   <= '0;
`ifdef LGATE_ARB_ILLEGAL_OP_EN
          err_q <= 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  assign busy = (state_q != IDLE);

`ifdef LGATE_ARB_ILLEGAL_OP_EN
  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule
